// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-subset datapath.
// Moore outputs decode from the state register; only PC_en also depends on Zero.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PC_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_control,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  // Returns {supported, alu_op}; unsupported functs fall back to add.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: decode_funct = {1'b1, ALU_ADD};
      6'b100010: decode_funct = {1'b1, ALU_SUB};
      6'b100100: decode_funct = {1'b1, ALU_AND};
      6'b100101: decode_funct = {1'b1, ALU_OR};
      6'b000000: decode_funct = {1'b1, ALU_SLL};
      6'b000010: decode_funct = {1'b1, ALU_SRL};
      default:   decode_funct = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_fdec;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;
  logic       w_pcwrite, w_branch;
  logic       w_iord, w_memread, w_memwrite, w_irwrite;
  logic       w_memtoreg, w_regdst, w_regwrite, w_alusrca, w_illegal;
  logic [1:0] w_alusrcb, w_pcsource;
  logic [2:0] w_alu;

  assign w_fdec      = decode_funct(funct);
  assign w_funct_ok  = w_fdec[3];
  assign w_funct_alu = w_fdec[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_illegal  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsource = 2'b00;
    w_alu      = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut for BRANCH to use.
        w_alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_alu     = w_funct_alu;
        w_illegal = ~w_funct_ok;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = w_funct_ok;
      end
      S_BRANCH: begin
        w_alusrca  = 1'b1;
        w_alu      = ALU_SUB;
        w_branch   = 1'b1;
        w_pcsource = 2'b01;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, even though the state already reads FETCH.
  assign PC_en       = ~reset & (w_pcwrite | (w_branch & Zero));
  assign IorD        = ~reset & w_iord;
  assign MemRead     = ~reset & w_memread;
  assign MemWrite    = ~reset & w_memwrite;
  assign IRWrite     = ~reset & w_irwrite;
  assign MemtoReg    = ~reset & w_memtoreg;
  assign RegDst      = ~reset & w_regdst;
  assign RegWrite    = ~reset & w_regwrite;
  assign ALUSrcA     = ~reset & w_alusrca;
  assign illegal     = ~reset & w_illegal;
  assign ALUSrcB     = reset ? 2'b00 : w_alusrcb;
  assign PCSource    = reset ? 2'b00 : w_pcsource;
  assign ALU_control = reset ? 3'b000 : w_alu;
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic       clk, reset, Zero;
  logic [5:0] opcode, funct;
  logic       PC_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_control;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .PC_en(PC_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_control(ALU_control), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH and checks its cycle count (bounded).
  task automatic run_count(input logic [5:0] op, input logic [5:0] fn, input int exp_n, input string tag);
    int n;
    opcode = op;
    funct  = fn;
    chk({tag, "_fetch_state"}, state, 0);
    chk({tag, "_fetch_pcen"}, PC_en, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state == 4'd0) break;
      n++;
    end
    chk({tag, "_cycles"}, n, exp_n);
  endtask

  // Pulses reset mid-cycle; checks outputs drop before the next edge, then resyncs.
  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_state"}, state, 0);
    chk({tag, "_memwrite"}, MemWrite, 0);
    chk({tag, "_regwrite"}, RegWrite, 0);
    chk({tag, "_pcen"}, PC_en, 0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000, 6'b000010};
  int         alu_tab [6] = '{0, 1, 2, 3, 4, 5};

  initial begin
    reset  = 1'b1;
    opcode = 6'b0;
    funct  = 6'b0;
    Zero   = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_pcen", PC_en, 0);
    chk("rst_alusrcb", ALUSrcB, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rel_state", state, 0);
    chk("rel_memread", MemRead, 1);
    chk("rel_irwrite", IRWrite, 1);
    chk("rel_alusrcb", ALUSrcB, 1);

    // lw
    opcode = 6'b100011;
    tick();
    chk("lw_decode", state, 1);
    chk("lw_dec_alusrcb", ALUSrcB, 3);
    tick();
    chk("lw_memadr", state, 2);
    chk("lw_adr_alusrcb", ALUSrcB, 2);
    chk("lw_adr_alusrca", ALUSrcA, 1);
    tick();
    chk("lw_memrd", state, 3);
    chk("lw_rd_memread", MemRead, 1);
    chk("lw_rd_iord", IorD, 1);
    tick();
    chk("lw_memwb", state, 4);
    chk("lw_wb_regwrite", RegWrite, 1);
    chk("lw_wb_memtoreg", MemtoReg, 1);
    chk("lw_wb_regdst", RegDst, 0);
    tick();
    chk("lw_back", state, 0);

    // R-type, all supported functs
    opcode = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = fn_tab[k];
      tick();
      tick();
      chk($sformatf("r%0d_exec", k), state, 6);
      chk($sformatf("r%0d_alu", k), ALU_control, alu_tab[k]);
      chk($sformatf("r%0d_illegal", k), illegal, 0);
      tick();
      chk($sformatf("r%0d_aluwb", k), state, 7);
      chk($sformatf("r%0d_regwrite", k), RegWrite, 1);
      chk($sformatf("r%0d_regdst", k), RegDst, 1);
      tick();
      chk($sformatf("r%0d_back", k), state, 0);
    end

    // R-type unsupported funct
    funct = 6'b111111;
    tick();
    tick();
    chk("rbad_exec", state, 6);
    chk("rbad_illegal", illegal, 1);
    chk("rbad_alu", ALU_control, 0);
    tick();
    chk("rbad_aluwb", state, 7);
    chk("rbad_regwrite", RegWrite, 0);
    chk("rbad_illegal_end", illegal, 0);
    tick();

    // beq taken and not taken
    opcode = 6'b000100;
    funct  = 6'b0;
    Zero   = 1'b1;
    tick();
    tick();
    chk("beq1_state", state, 8);
    chk("beq1_pcen", PC_en, 1);
    chk("beq1_pcsource", PCSource, 1);
    chk("beq1_alu", ALU_control, 1);
    tick();
    chk("beq1_back", state, 0);
    Zero = 1'b0;
    tick();
    tick();
    chk("beq0_state", state, 8);
    chk("beq0_pcen", PC_en, 0);
    tick();
    chk("beq0_back", state, 0);

    // illegal opcode
    opcode = 6'b111111;
    tick();
    chk("ill_decode", state, 1);
    chk("ill_pulse", illegal, 1);
    chk("ill_regwrite", RegWrite, 0);
    chk("ill_memwrite", MemWrite, 0);
    tick();
    chk("ill_back", state, 0);
    chk("ill_pulse_end", illegal, 0);
    run_count(6'b111111, 6'b0, 2, "ill_cnt");

    // reset during MEMWR
    opcode = 6'b101011;
    tick();
    tick();
    tick();
    chk("sw_memwr", state, 5);
    chk("sw_memwrite", MemWrite, 1);
    reset_pulse("rst_memwr");
    chk("rst_memwr_resume", state, 0);

    // reset during ALUWB
    opcode = 6'b000000;
    funct  = 6'b100000;
    tick();
    tick();
    tick();
    chk("add_aluwb", state, 7);
    chk("add_regwrite", RegWrite, 1);
    reset_pulse("rst_aluwb");

    // back-to-back sw, addi, j
    run_count(6'b101011, 6'b0, 4, "sw");
    run_count(6'b001000, 6'b0, 4, "addi");
    opcode = 6'b000010;
    chk("j_fetch_pcen", PC_en, 1);
    tick();
    chk("j_decode", state, 1);
    tick();
    chk("j_state", state, 11);
    chk("j_pcen", PC_en, 1);
    chk("j_pcsource", PCSource, 2);
    tick();
    chk("j_back", state, 0);
    run_count(6'b000010, 6'b0, 3, "j");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; opcode, funct and ALU_control encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 opcode  input  6  instr[31:26] from external instruction register; stable from DECODE until the return to FETCH.
REQ-005 funct  input  6  instr[5:0]; stable under the same rule as opcode.
REQ-006 Zero  input  1  ALU zero flag, sampled combinationally in BRANCH.
REQ-007 PC_en  output  1  PC load = PCWrite | (Branch & Zero).
REQ-008 IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-009 ALUSrcB  output  2  00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-010 PCSource  output  2  00 = ALU_result, 01 = ALUOut reg, 10 = jump target.
REQ-011 ALU_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl (the ALU's encoding).
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-013 state  output  4  current state code, for debug and the bench.

Function
REQ-014 The block SHALL be a Moore FSM; all outputs except PC_en are pure functions of state (plus funct in EXEC/ALUWB). Unlisted outputs are 0 in every state.
REQ-015 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH on the next edge with all outputs 0.
REQ-016 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALU_control=000, PCSource=00, PCWrite=1; next state DECODE.
REQ-017 DECODE: ALUSrcB=11, ALU_control=000 (branch target precompute). Next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with illegal=1.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_control=000; next state MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: MemRead=1, IorD=1; next state MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; next state FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00; ALU_control from funct: 100000 -> 000, 100010 -> 001, 100100 -> 010, 100101 -> 011, 000000 -> 100, 000010 -> 101, other -> 000 with illegal=1; next state ALUWB.
REQ-022 ALUWB: RegDst=1, MemtoReg=0; RegWrite=1 only for a supported funct, else 0; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_control=001, Branch=1, PCSource=01; PC_en = Zero in the same cycle; next state FETCH.
REQ-024 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_control=000; next state ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-026 Cycles per instruction, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-027 MemWrite, RegWrite and PC_en SHALL never be asserted in the same cycle as reset.

Reset
REQ-028 Asserting reset in any state SHALL force state=FETCH asynchronously; while reset is high, all outputs SHALL be 0 and illegal SHALL be 0.
REQ-029 On the first rising edge after reset deasserts, the FSM SHALL be in FETCH with FETCH outputs active; the next edge enters DECODE.

Verification
REQ-030 lw (opcode 100011): states 0,1,2,3,4,0. MEMRD has MemRead=1, IorD=1. MEMWB has RegWrite=1, MemtoReg=1.
REQ-031 R-type sub (000000/100010): ALU_control=001 in EXEC; ALUWB has RegWrite=1, RegDst=1. Repeat for all six functs. funct 111111 gives illegal=1 and RegWrite=0.
REQ-032 beq: Zero=1 in BRANCH gives PC_en=1, PCSource=01. Zero=0 gives PC_en=0. Either case returns to FETCH next cycle.
REQ-033 opcode 111111: DECODE gives illegal=1 for one cycle, then FETCH; no RegWrite or MemWrite at any point.
REQ-034 reset pulsed mid-MEMWR and mid-ALUWB: state=0 and MemWrite/RegWrite=0 immediately, before the next clock edge.
REQ-035 Back-to-back sw, addi, j: cycle counts 4, 4, 3. PC_en=1 in each FETCH and in JUMP.
